// File: rtl/fpu_cmp_pkg.sv
// rtl/fpu_cmp_pkg.sv - shared opcodes, constants and writeback entry type for the FP compare path
package fpu_cmp_pkg;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_LT  = 3'b001;
    localparam logic [2:0] OP_LE  = 3'b010;
    localparam logic [2:0] OP_MIN = 3'b100;
    localparam logic [2:0] OP_MAX = 3'b101;

    localparam logic [63:0] QNAN_DP   = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] QNAN_SP   = 32'h7FC0_0000;
    localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

    localparam int unsigned WB_TAG_W = 5;

    typedef struct packed {
        logic [63:0]         data;
        logic [WB_TAG_W-1:0] rd;
        logic                to_int;
        logic                nv;
    } wb_entry_t;

    typedef enum logic [1:0] {
        OP_CLASS_CMP,
        OP_CLASS_MINMAX,
        OP_CLASS_NONE
    } op_class_e;

    function automatic op_class_e classify_op(input logic [2:0] op);
        op_class_e cls;
        case (op)
            OP_EQ, OP_LT, OP_LE: cls = OP_CLASS_CMP;
            OP_MIN, OP_MAX:      cls = OP_CLASS_MINMAX;
            default:             cls = OP_CLASS_NONE;
        endcase
        return cls;
    endfunction

    // Compare results go to the integer file as 0/1; SP min/max are NaN-boxed for the FP file.
    function automatic wb_entry_t format_entry(
        input logic [2:0]          op,
        input logic                sp_dp,
        input logic [63:0]         result,
        input logic                invalid,
        input logic [WB_TAG_W-1:0] rd
    );
        wb_entry_t e;
        e    = '0;
        e.rd = rd;
        case (classify_op(op))
            OP_CLASS_CMP: begin
                e.data   = {63'b0, result[0]};
                e.to_int = 1'b1;
                e.nv     = invalid;
            end
            OP_CLASS_MINMAX: begin
                e.data   = sp_dp ? result : {NANBOX_HI, result[31:0]};
                e.to_int = 1'b0;
                e.nv     = 1'b0;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/fcmp_wb_fifo.sv
// rtl/fcmp_wb_fifo.sv - DEPTH-entry synchronous FIFO of writeback entries with flush
module fcmp_wb_fifo
    import fpu_cmp_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             flush,
    output wb_entry_t        head_entry,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head_entry = mem_q[rd_ptr_q];

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fcmp_writeback_stage.sv
// rtl/fcmp_writeback_stage.sv - buffered writeback of FP compare/min/max results with sticky NV
module fcmp_writeback_stage
    import fpu_cmp_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [63:0]      IN_OUTPUT,
    input  logic             IN_INVALID,
    input  logic             IN_SP_DP,
    input  logic [2:0]       IN_OPERATION,
    input  logic [TAG_W-1:0] IN_RD,
    input  logic             FLUSH,
    output logic             WB_VALID,
    input  logic             WB_READY,
    output logic [63:0]      WB_DATA,
    output logic [TAG_W-1:0] WB_RD,
    output logic             WB_TO_INT,
    output logic             FFLAGS_NV,
    input  logic             FFLAGS_CLR
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             op_known;
    logic             push, pop;
    logic             nv_q, nv_d;

    // Ready depends only on occupancy and reset, never on WB_READY.
    assign IN_READY = !fifo_full && !RST;
    assign op_known = (classify_op(IN_OPERATION) != OP_CLASS_NONE);
    assign push     = IN_VALID && IN_READY && op_known;

    assign WB_VALID = (fifo_count != '0);
    assign pop      = WB_VALID && WB_READY && !fifo_empty;

    assign push_entry = format_entry(IN_OPERATION, IN_SP_DP, IN_OUTPUT, IN_INVALID,
                                     WB_TAG_W'(IN_RD));

    assign WB_DATA   = head_entry.data;
    assign WB_RD     = TAG_W'(head_entry.rd);
    assign WB_TO_INT = head_entry.to_int;
    assign FFLAGS_NV = nv_q;

    fcmp_wb_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (FLUSH),
        .head_entry (head_entry),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // NV is raised at retirement so flushed entries never reach the flag; set beats clear.
    always_comb begin
        nv_d = nv_q;
        if (FFLAGS_CLR) begin
            nv_d = 1'b0;
        end
        if (pop && head_entry.nv) begin
            nv_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nv_q <= 1'b0;
        end else begin
            nv_q <= nv_d;
        end
    end

endmodule

// File: tb/tb_fcmp_writeback_stage.sv
// tb/tb_fcmp_writeback_stage.sv - directed self-checking bench for fcmp_writeback_stage
module tb_fcmp_writeback_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] IN_OUTPUT;
    logic        IN_INVALID;
    logic        IN_SP_DP;
    logic [2:0]  IN_OPERATION;
    logic [4:0]  IN_RD;
    logic        FLUSH;
    logic        WB_VALID;
    logic        WB_READY;
    logic [63:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_TO_INT;
    logic        FFLAGS_NV;
    logic        FFLAGS_CLR;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fcmp_writeback_stage #(.DEPTH(2), .TAG_W(5)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_OUTPUT    (IN_OUTPUT),
        .IN_INVALID   (IN_INVALID),
        .IN_SP_DP     (IN_SP_DP),
        .IN_OPERATION (IN_OPERATION),
        .IN_RD        (IN_RD),
        .FLUSH        (FLUSH),
        .WB_VALID     (WB_VALID),
        .WB_READY     (WB_READY),
        .WB_DATA      (WB_DATA),
        .WB_RD        (WB_RD),
        .WB_TO_INT    (WB_TO_INT),
        .FFLAGS_NV    (FFLAGS_NV),
        .FFLAGS_CLR   (FFLAGS_CLR)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic dp,
                         input logic [63:0] res, input logic inv, input logic [4:0] rd);
        IN_VALID     = v;
        IN_OPERATION = op;
        IN_SP_DP     = dp;
        IN_OUTPUT    = res;
        IN_INVALID   = inv;
        IN_RD        = rd;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, 64'h0, 1'b0, 5'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; FLUSH = 1'b0; WB_READY = 1'b0; FFLAGS_CLR = 1'b0;
        idle();
        step(); step();
        check("rst_wb_valid", WB_VALID, 0);
        check("rst_wb_data", WB_DATA, 0);
        check("rst_wb_rd", WB_RD, 0);
        check("rst_wb_to_int", WB_TO_INT, 0);
        check("rst_nv", FFLAGS_NV, 0);
        check("rst_in_ready", IN_READY, 0);
        RST = 1'b0;
        #1;
        check("rel_in_ready", IN_READY, 1);

        // SP MIN is NaN-boxed, one-cycle latency
        WB_READY = 1'b1;
        drive(1'b1, 3'b100, 1'b0, 64'h0000_0000_3F80_0000, 1'b0, 5'd3);
        step(); idle();
        check("spmin_valid", WB_VALID, 1);
        check("spmin_data", WB_DATA, 64'hFFFF_FFFF_3F80_0000);
        check("spmin_to_int", WB_TO_INT, 0);
        check("spmin_rd", WB_RD, 3);
        step();
        check("spmin_drained", WB_VALID, 0);

        // LT with invalid: NV on retirement, cleared by FFLAGS_CLR
        WB_READY = 1'b0;
        drive(1'b1, 3'b001, 1'b1, 64'hFFFF_0000_0000_0003, 1'b1, 5'd7);
        step(); idle();
        check("lt_data", WB_DATA, 64'h1);
        check("lt_rd", WB_RD, 7);
        check("lt_to_int", WB_TO_INT, 1);
        check("lt_nv_before_retire", FFLAGS_NV, 0);
        WB_READY = 1'b1;
        step();
        check("lt_nv_after_retire", FFLAGS_NV, 1);
        check("lt_drained", WB_VALID, 0);
        FFLAGS_CLR = 1'b1;
        step();
        FFLAGS_CLR = 1'b0;
        check("lt_nv_cleared", FFLAGS_NV, 0);

        // Fill with DP MAX while stalled, third rejected, then drain in order
        WB_READY = 1'b0;
        drive(1'b1, 3'b101, 1'b1, 64'h4000_0000_0000_0001, 1'b1, 5'd1);
        step();
        check("full_rdy_after1", IN_READY, 1);
        drive(1'b1, 3'b101, 1'b1, 64'hC010_0000_0000_0002, 1'b0, 5'd2);
        step();
        check("full_rdy_after2", IN_READY, 0);
        drive(1'b1, 3'b101, 1'b1, 64'h7FF8_0000_0000_0000, 1'b0, 5'd3);
        step();
        check("full_rdy_reject", IN_READY, 0);
        check("full_hold_data", WB_DATA, 64'h4000_0000_0000_0001);
        check("full_hold_rd", WB_RD, 1);
        check("full_hold_to_int", WB_TO_INT, 0);
        WB_READY = 1'b1;
        step();
        check("drain1_data", WB_DATA, 64'hC010_0000_0000_0002);
        check("drain1_rd", WB_RD, 2);
        check("drain1_in_ready", IN_READY, 1);
        step();
        check("drain2_data", WB_DATA, 64'h7FF8_0000_0000_0000);
        check("drain2_rd", WB_RD, 3);
        check("drain2_valid", WB_VALID, 1);
        idle();
        step();
        check("drain3_valid", WB_VALID, 0);
        check("minmax_nv_clear", FFLAGS_NV, 0);

        // Flush drops stalled EQ-invalid entry and a same-cycle push
        WB_READY = 1'b0;
        drive(1'b1, 3'b000, 1'b0, 64'h1, 1'b1, 5'd4);
        step(); idle();
        check("flush_pre_valid", WB_VALID, 1);
        FLUSH = 1'b1;
        drive(1'b1, 3'b000, 1'b0, 64'h1, 1'b1, 5'd5);
        step();
        FLUSH = 1'b0; idle();
        check("flush_valid", WB_VALID, 0);
        check("flush_nv", FFLAGS_NV, 0);
        step();
        check("flush_push_dropped", WB_VALID, 0);

        // Pop in the flush cycle still retires
        drive(1'b1, 3'b000, 1'b0, 64'h0, 1'b1, 5'd9);
        step(); idle();
        WB_READY = 1'b1; FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("flush_pop_nv", FFLAGS_NV, 1);
        check("flush_pop_valid", WB_VALID, 0);
        FFLAGS_CLR = 1'b1;
        step();
        FFLAGS_CLR = 1'b0;
        check("clr_again", FFLAGS_NV, 0);

        // Clear and set together: set wins
        WB_READY = 1'b0;
        drive(1'b1, 3'b010, 1'b0, 64'h0, 1'b1, 5'd10);
        step(); idle();
        check("le_data", WB_DATA, 64'h0);
        check("le_to_int", WB_TO_INT, 1);
        WB_READY = 1'b1; FFLAGS_CLR = 1'b1;
        step();
        FFLAGS_CLR = 1'b0;
        check("set_beats_clr", FFLAGS_NV, 1);

        // Undefined opcodes handshake but are dropped
        drive(1'b1, 3'b110, 1'b0, 64'h1, 1'b1, 5'd11);
        #1;
        check("undef_in_ready", IN_READY, 1);
        step();
        drive(1'b1, 3'b011, 1'b0, 64'h1, 1'b1, 5'd12);
        step(); idle();
        check("undef_no_valid", WB_VALID, 0);
        step();
        check("undef_nv_kept", FFLAGS_NV, 1);

        // Async reset with two entries buffered
        WB_READY = 1'b0;
        drive(1'b1, 3'b101, 1'b0, 64'h0000_0000_4049_0FDB, 1'b0, 5'd13);
        step();
        drive(1'b1, 3'b101, 1'b0, 64'h0000_0000_C000_0000, 1'b0, 5'd14);
        step(); idle();
        check("prerst_valid", WB_VALID, 1);
        check("prerst_in_ready", IN_READY, 0);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_valid", WB_VALID, 0);
        check("async_rst_nv", FFLAGS_NV, 0);
        check("async_rst_data", WB_DATA, 0);
        check("async_rst_in_ready", IN_READY, 0);
        step();
        RST = 1'b0;
        #1;
        check("rerel_in_ready", IN_READY, 1);
        check("rerel_valid", WB_VALID, 0);
        drive(1'b1, 3'b101, 1'b0, 64'h1234_5678_C000_0000, 1'b0, 5'd31);
        step(); idle();
        check("post_rst_data", WB_DATA, 64'hFFFF_FFFF_C000_0000);
        check("post_rst_rd", WB_RD, 31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fcmp_writeback_stage.md
# fcmp_writeback_stage

Registered writeback stage placed directly downstream of the FP compare/min/max combinational unit. Accepts each result through a valid/ready handshake and formats it for the register file: compare results are zero-extended for the integer file, and SP min/max results are NaN-boxed. Results are buffered in a small FIFO so the issue side is decoupled from writeback stalls. The stage also keeps the sticky invalid-operation flag (NV) for retired compare operations.

## Interface
- DEPTH, 2: FIFO entries (≥2).
- TAG_W, 5: destination register tag width.
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN_VALID  in  1  upstream result valid.
- IN_READY  out  1  stage can accept.
- IN_OUTPUT  in  64  compare unit OUTPUT.
- IN_INVALID  in  1  compare unit INVALID.
- IN_SP_DP  in  1  1 = DP, 0 = SP.
- IN_OPERATION  in  3  000 EQ, 001 LT, 010 LE, 100 MIN, 101 MAX.
- IN_RD  in  TAG_W  destination tag.
- FLUSH  in  1  discard all buffered entries.
- WB_VALID  out  1  head entry valid.
- WB_READY  in  1  register file accepts.
- WB_DATA  out  64  formatted result.
- WB_RD  out  TAG_W  destination tag.
- WB_TO_INT  out  1  1 = integer register file, 0 = FP register file.
- FFLAGS_NV  out  1  sticky invalid flag.
- FFLAGS_CLR  in  1  clear sticky flag.

## Operation
- Push occurs when IN_VALID & IN_READY.
- IN_READY = (count < DEPTH) & !RST.
- There is no combinational path from WB_READY to IN_READY. When the FIFO is full, no push occurs, even if a pop happens in the same cycle.
- Formatting is applied at push time, and the formatted value is stored:
  - EQ/LT/LE: data = {63'b0, IN_OUTPUT[0]}, to_int = 1.
  - MIN/MAX, DP: data = IN_OUTPUT, to_int = 0.
  - MIN/MAX, SP: data = {32'hFFFF_FFFF, IN_OUTPUT[31:0]}, to_int = 0.
- The stored nv bit = IN_INVALID for EQ/LT/LE, and 0 for MIN/MAX.
- Undefined opcodes (011, 110, 111) complete the handshake but are dropped: no entry is written and no flag is recorded.
- Pop occurs when WB_VALID & WB_READY.
- WB_* are driven from the head entry. WB_VALID = (count != 0).
- Count updates: +1 on push only, −1 on pop only, unchanged on push and pop together. Pointers wrap modulo DEPTH.
- FFLAGS_NV is set on the cycle after a pop whose entry has nv = 1. The flag is set at retirement, not at push, so flushed entries never raise it.
- FFLAGS_CLR clears the flag next cycle. If a clear and a set occur in the same cycle, the set wins.
- FLUSH sets count and pointers to 0 next cycle:
  - A push in the same cycle is discarded.
  - A pop in the same cycle is still treated as retired and may set NV.
- While WB_VALID = 1 and WB_READY = 0, WB_DATA, WB_RD and WB_TO_INT must hold stable.

## Timing
- Reset values: count 0, WB_VALID 0, WB_DATA 0, WB_RD 0, WB_TO_INT 0, FFLAGS_NV 0, IN_READY 0.
- IN_READY rises in the first cycle after RST deasserts.
- Assertion of RST mid-operation drops all entries immediately (asynchronous).
- Latency: a push in cycle N into an empty FIFO gives WB_VALID = 1 in cycle N+1.
- Throughput: one result per cycle, sustained, with DEPTH ≥ 2 and WB_READY held high.
- Full: after DEPTH pushes with WB_READY = 0, IN_READY = 0. IN_READY returns to 1 the cycle after the first pop.
- Empty: WB_VALID = 0. WB_DATA holds the last value and is don't-care.

## Structure
- Shared package fpu_cmp_pkg holds:
  - opcode constants OP_EQ, OP_LT, OP_LE, OP_MIN, OP_MAX (shared with the compare unit);
  - QNAN_DP and QNAN_SP;
  - NANBOX_HI = 32'hFFFF_FFFF;
  - a packed entry struct {data[63:0], rd, to_int, nv}.
- Sub-module fcmp_wb_fifo: generic DEPTH-entry synchronous FIFO of the entry struct, with push, pop, flush, count, full and empty.
- The top level contains only the formatting logic, the handshake and the sticky flag.

## Test plan
- SP MIN with IN_OUTPUT = 64'h0000_0000_3F80_0000, WB_READY = 1 → next cycle WB_VALID = 1, WB_DATA = 64'hFFFF_FFFF_3F80_0000, WB_TO_INT = 0.
- LT with IN_OUTPUT = 1, IN_INVALID = 1, IN_RD = 5'd7 → WB_DATA = 64'h1, WB_RD = 7, WB_TO_INT = 1; FFLAGS_NV = 1 the cycle after retirement; asserting FFLAGS_CLR returns it to 0.
- Hold WB_READY = 0 and push 3 DP MAX results → IN_READY = 0 after the 2nd push; the 3rd is not accepted. Raise WB_READY → entries drain in order, unchanged, and IN_READY returns to 1.
- Push EQ with IN_INVALID = 1, stall, then assert FLUSH → WB_VALID = 0 next cycle and FFLAGS_NV stays 0.
- Opcode 3'b110 with IN_VALID = 1 → IN_READY = 1, no WB_VALID, FFLAGS_NV unchanged.
- Assert RST while 2 entries are buffered → WB_VALID = 0 and FFLAGS_NV = 0 immediately; IN_READY = 1 the first cycle after release.
